// File: rtl/distance_calculator_pkg.sv
// Shared types and burst-geometry helpers for the KNN distance stage.
// Included by the top level and any block that needs burst sizing.
package distance_calculator_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ACC  = 3'd1,
        S_REQ  = 3'd2,
        S_WAIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam int DEF_M            = 6;
    localparam int DEF_N            = 10;
    localparam int DEF_W            = 32;
    localparam int DEF_MAX_ELEMENTS = 16;
    localparam int DEF_TYPE_W       = 2;

    // Number of bursts needed to carry `total` elements, `lanes` per burst.
    function automatic int burst_count(input int total, input int lanes);
        return (total + lanes - 1) / lanes;
    endfunction

    // Valid lanes in the final burst (always 1..lanes).
    function automatic int last_burst_lanes(input int total, input int lanes);
        return total - (burst_count(total, lanes) - 1) * lanes;
    endfunction

endpackage

// File: rtl/distance_calculator_abs.sv
// W-bit unsigned absolute difference |a-b|, computed as max-min so it never overflows.
module knn_abs_diff #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_diff
);

    // Subtract the smaller operand from the larger one.
    always_comb begin
        if (i_a >= i_b) begin
            o_diff = i_a - i_b;
        end else begin
            o_diff = i_b - i_a;
        end
    end

endmodule

// File: rtl/distance_calculator.sv
// Per-sample Manhattan distance between a training vector and an input vector,
// streamed in bursts of MAX_ELEMENTS lanes and accumulated one lane per cycle.
module distance_calculator
    import distance_calculator_pkg::*;
#(
    parameter int M            = DEF_M,
    parameter int N            = DEF_N,
    parameter int W            = DEF_W,
    parameter int MAX_ELEMENTS = DEF_MAX_ELEMENTS,
    parameter int TYPE_W       = DEF_TYPE_W
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_ready,
    input  logic [W*MAX_ELEMENTS-1:0] i_training_data,
    input  logic [TYPE_W-1:0]         i_training_data_type,
    input  logic [W*MAX_ELEMENTS-1:0] i_input_data,
    output logic [W-1:0]              o_distance,
    output logic [TYPE_W-1:0]         o_data_type,
    output logic                      o_done,
    output logic                      o_data_request
);

    localparam int T       = M * N;
    localparam int B       = burst_count(T, MAX_ELEMENTS);
    localparam int LAST_L  = last_burst_lanes(T, MAX_ELEMENTS);
    localparam int LANE_W  = (MAX_ELEMENTS > 1) ? $clog2(MAX_ELEMENTS) : 1;
    localparam int BURST_W = (B > 1) ? $clog2(B) : 1;

    localparam logic [LANE_W-1:0]  FULL_END    = LANE_W'(MAX_ELEMENTS - 1);
    localparam logic [LANE_W-1:0]  LAST_END    = LANE_W'(LAST_L - 1);
    localparam logic [BURST_W-1:0] FINAL_BURST = BURST_W'(B - 1);

    state_t              r_state;
    logic [W-1:0]        r_train [MAX_ELEMENTS];
    logic [W-1:0]        r_input [MAX_ELEMENTS];
    logic [TYPE_W-1:0]   r_label;
    logic [W-1:0]        r_acc;
    logic [LANE_W-1:0]   r_lane;
    logic [BURST_W-1:0]  r_burst;
    logic [W-1:0]        r_distance;
    logic [TYPE_W-1:0]   r_data_type;
    logic                r_done;
    logic                r_data_request;

    logic [W-1:0]        w_t;
    logic [W-1:0]        w_x;
    logic [W-1:0]        w_diff;
    logic [W-1:0]        w_sum;
    logic                w_final_burst;
    logic                w_last_lane;

    // Lane mux and end-of-burst detection; the final burst may be short.
    always_comb begin
        w_t           = r_train[r_lane];
        w_x           = r_input[r_lane];
        w_final_burst = (r_burst == FINAL_BURST);
        if (w_final_burst) begin
            w_last_lane = (r_lane == LAST_END);
        end else begin
            w_last_lane = (r_lane == FULL_END);
        end
        w_sum = r_acc + w_diff;
    end

    knn_abs_diff #(
        .W(W)
    ) u_abs_diff (
        .i_a    (w_t),
        .i_b    (w_x),
        .o_diff (w_diff)
    );

    // Control FSM, capture registers, accumulator and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_label        <= '0;
            r_acc          <= '0;
            r_lane         <= '0;
            r_burst        <= '0;
            r_distance     <= '0;
            r_data_type    <= '0;
            r_done         <= 1'b0;
            r_data_request <= 1'b0;
            for (int k = 0; k < MAX_ELEMENTS; k++) begin
                r_train[k] <= '0;
                r_input[k] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_ready) begin
                        for (int k = 0; k < MAX_ELEMENTS; k++) begin
                            r_train[k] <= i_training_data[(k+1)*W-1 -: W];
                            r_input[k] <= i_input_data[(k+1)*W-1 -: W];
                        end
                        r_label <= i_training_data_type;
                        r_acc   <= '0;
                        r_lane  <= '0;
                        r_burst <= '0;
                        r_state <= S_ACC;
                    end
                end
                S_ACC: begin
                    r_acc <= w_sum;
                    if (w_last_lane) begin
                        r_lane <= '0;
                        // Outputs are staged here so they are visible in the DONE/REQ cycle.
                        if (w_final_burst) begin
                            r_distance  <= w_sum;
                            r_data_type <= r_label;
                            r_done      <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_data_request <= 1'b1;
                            r_state        <= S_REQ;
                        end
                    end else begin
                        r_lane <= r_lane + LANE_W'(1);
                    end
                end
                S_REQ: begin
                    r_data_request <= 1'b0;
                    r_burst        <= r_burst + BURST_W'(1);
                    r_state        <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_ready) begin
                        for (int k = 0; k < MAX_ELEMENTS; k++) begin
                            r_train[k] <= i_training_data[(k+1)*W-1 -: W];
                            r_input[k] <= i_input_data[(k+1)*W-1 -: W];
                        end
                        r_lane  <= '0;
                        r_state <= S_ACC;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done         <= 1'b0;
                    r_data_request <= 1'b0;
                    r_state        <= S_IDLE;
                end
            endcase
        end
    end

    assign o_distance     = r_distance;
    assign o_data_type    = r_data_type;
    assign o_done         = r_done;
    assign o_data_request = r_data_request;

endmodule

// File: tb/tb_distance_calculator.sv
// Self-checking bench: three distance_calculator instances (T=60, T=8, T=2)
// share the data buses and are driven one at a time against a plain-arithmetic model.
module tb_distance_calculator;

    localparam int W  = 32;
    localparam int ML = 16;
    localparam int BW = W * ML;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [BW-1:0] tdata;
    logic [BW-1:0] xdata;
    logic [1:0]    ttype;
    logic          ready_v [3];
    logic [W-1:0]  dist_v  [3];
    logic [1:0]    dtype_v [3];
    logic          done_v  [3];
    logic          dreq_v  [3];

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] tv [64];
    logic [W-1:0] xv [64];

    distance_calculator #(.M(6), .N(10), .W(W), .MAX_ELEMENTS(ML), .TYPE_W(2)) u_dut_main (
        .i_clk(clk), .i_rst(rst), .i_ready(ready_v[0]),
        .i_training_data(tdata), .i_training_data_type(ttype), .i_input_data(xdata),
        .o_distance(dist_v[0]), .o_data_type(dtype_v[0]),
        .o_done(done_v[0]), .o_data_request(dreq_v[0]));

    distance_calculator #(.M(2), .N(4), .W(W), .MAX_ELEMENTS(ML), .TYPE_W(2)) u_dut_small (
        .i_clk(clk), .i_rst(rst), .i_ready(ready_v[1]),
        .i_training_data(tdata), .i_training_data_type(ttype), .i_input_data(xdata),
        .o_distance(dist_v[1]), .o_data_type(dtype_v[1]),
        .o_done(done_v[1]), .o_data_request(dreq_v[1]));

    distance_calculator #(.M(1), .N(2), .W(W), .MAX_ELEMENTS(ML), .TYPE_W(2)) u_dut_wrap (
        .i_clk(clk), .i_rst(rst), .i_ready(ready_v[2]),
        .i_training_data(tdata), .i_training_data_type(ttype), .i_input_data(xdata),
        .o_distance(dist_v[2]), .o_data_type(dtype_v[2]),
        .o_done(done_v[2]), .o_data_request(dreq_v[2]));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: sum of |t-x| over the whole vector, wrapping at 2^W.
    function automatic logic [W-1:0] model_dist(input int t);
        logic [W-1:0] s;
        s = '0;
        for (int i = 0; i < t; i++) begin
            if (tv[i] > xv[i]) s = s + (tv[i] - xv[i]);
            else               s = s + (xv[i] - tv[i]);
        end
        return s;
    endfunction

    task automatic load_burst(input int b, input int t);
        for (int k = 0; k < ML; k++) begin
            if (b * ML + k < t) begin
                tdata[k*W +: W] = tv[b*ML + k];
                xdata[k*W +: W] = xv[b*ML + k];
            end else begin
                tdata[k*W +: W] = $urandom;
                xdata[k*W +: W] = $urandom;
            end
        end
    endtask

    task automatic scramble();
        for (int k = 0; k < ML; k++) begin
            tdata[k*W +: W] = $urandom;
            xdata[k*W +: W] = $urandom;
        end
    endtask

    // Drive one full vector into instance `which`; abort_at>=0 resets during that burst.
    task automatic run_vec(input int which, input int t, input logic [1:0] label,
                           input bit extra, input int abort_at);
        int nb, len, cnt, reqs;
        bit got;
        logic [W-1:0] exp_d;
        nb    = (t + ML - 1) / ML;
        reqs  = 0;
        exp_d = model_dist(t);
        for (int b = 0; b < nb; b++) begin
            len = (b == nb - 1) ? (t - b * ML) : ML;
            load_burst(b, t);
            if (b == 0) ttype = label;
            ready_v[which] = 1'b1;
            @(negedge clk);
            ready_v[which] = 1'b0;
            scramble();
            if (b == 0) ttype = label ^ 2'b11;
            cnt = 1;
            got = 1'b0;
            while (!got && cnt < 40) begin
                if (dreq_v[which] || done_v[which]) begin
                    got = 1'b1;
                end else begin
                    ready_v[which] = extra && (cnt == 2) && (len > 3);
                    if (abort_at == b && cnt == 3) begin
                        rst = 1'b1;
                        @(negedge clk);
                        @(negedge clk);
                        check("rst_distance", dist_v[which], 0);
                        check("rst_data_type", dtype_v[which], 0);
                        check("rst_done", done_v[which], 0);
                        check("rst_request", dreq_v[which], 0);
                        rst = 1'b0;
                        ready_v[which] = 1'b0;
                        for (int c = 0; c < 5; c++) begin
                            @(negedge clk);
                            check("no_done_after_abort", {dreq_v[which], done_v[which]}, 2'b00);
                        end
                        return;
                    end
                    @(negedge clk);
                    cnt++;
                end
            end
            ready_v[which] = 1'b0;
            check("pulse_timeout", got, 1);
            if (!got) return;
            check("pulse_latency", cnt, len + 1);
            if (b < nb - 1) begin
                check("expect_request", {dreq_v[which], done_v[which]}, 2'b10);
                reqs++;
                @(negedge clk);
                check("request_one_cycle", dreq_v[which], 0);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end else begin
                check("expect_done", {dreq_v[which], done_v[which]}, 2'b01);
                check("distance", dist_v[which], exp_d);
                check("data_type", dtype_v[which], label);
                check("request_count", reqs, nb - 1);
                ready_v[which] = extra;
                @(negedge clk);
                ready_v[which] = 1'b0;
                check("done_one_cycle", done_v[which], 0);
                check("distance_hold", dist_v[which], exp_d);
                check("data_type_hold", dtype_v[which], label);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) ready_v[i] = 1'b0;
        tdata = '0;
        xdata = '0;
        ttype = 2'b00;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("reset_distance", dist_v[i], 0);
            check("reset_data_type", dtype_v[i], 0);
            check("reset_done", done_v[i], 0);
            check("reset_request", dreq_v[i], 0);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // All-ones training vs all-zeros input: distance 60, three requests.
        for (int i = 0; i < 60; i++) begin
            tv[i] = 32'd1;
            xv[i] = 32'd0;
        end
        run_vec(0, 60, 2'd2, 1'b0, -1);

        // Back-to-back random vectors with growing element range.
        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < 60; i++) begin
                tv[i] = $urandom_range(0, (v + 1) * 100);
                xv[i] = $urandom_range(0, (v + 1) * 100);
            end
            run_vec(0, 60, 2'($urandom_range(0, 3)), v == 1, -1);
        end

        // Single-burst instance: only elements 0 and 1 differ, by 5 each.
        for (int i = 0; i < 8; i++) begin
            tv[i] = $urandom_range(0, 1000);
            xv[i] = tv[i];
        end
        tv[0] = 32'd5; xv[0] = 32'd0;
        tv[1] = 32'd0; xv[1] = 32'd5;
        run_vec(1, 8, 2'd1, 1'b1, -1);

        // Accumulator wrap: two maximal differences.
        tv[0] = 32'hFFFF_FFFF; xv[0] = 32'd0;
        tv[1] = 32'hFFFF_FFFF; xv[1] = 32'd0;
        run_vec(2, 2, 2'd3, 1'b0, -1);

        // Reset during burst 2, then a fresh vector.
        for (int i = 0; i < 60; i++) begin
            tv[i] = $urandom_range(0, 500);
            xv[i] = $urandom_range(0, 500);
        end
        run_vec(0, 60, 2'd1, 1'b0, 2);
        for (int i = 0; i < 60; i++) begin
            tv[i] = $urandom;
            xv[i] = $urandom;
        end
        run_vec(0, 60, 2'd2, 1'b1, -1);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/distance_calculator.md
# distance_calculator

Computes the Manhattan distance (sum of absolute element differences) between one training vector and one input vector of M*N unsigned W-bit elements. The block is the per-sample distance stage of the KNN system. Vectors arrive in bursts of at most MAX_ELEMENTS lanes under a ready/data_request handshake. It outputs the distance and the training sample's class label.

## Interface
- M, 6: matrix rows; vector length is T = M*N.
- N, 10: matrix columns.
- W, 32: element, accumulator and distance width.
- MAX_ELEMENTS, 16: lanes per burst.
- TYPE_W, 2: class-label width.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; asynchronous and active-high.
- ready  in  1  burst-valid strobe; sampled high = lanes are valid this cycle.
- training_data  in  W*MAX_ELEMENTS  training lanes; lane k = bits [(k+1)*W-1 -: W].
- training_data_type  in  TYPE_W  class label of the training vector.
- input_data  in  W*MAX_ELEMENTS  input lanes, same packing.
- distance  out  W  result; held until next result.
- data_type  out  TYPE_W  label of the vector that produced distance.
- done  out  1  one-cycle pulse when distance/data_type update.
- data_request  out  1  one-cycle pulse requesting the next burst.

## Operation
- Bursts: B = ceil(T/MAX_ELEMENTS). Bursts 0..B-2 carry MAX_ELEMENTS valid lanes. The last burst carries T-(B-1)*MAX_ELEMENTS lanes, packed at lanes 0 upward; unused lanes are ignored.
- Element order: global element i sits in burst i/MAX_ELEMENTS, lane i%MAX_ELEMENTS.
- All elements are unsigned. Each step adds |t-x| (computed as max-min, fits W bits). The accumulator is W bits and wraps modulo 2^W.
- States: IDLE, ACC, REQ, WAIT, DONE.
  - IDLE: ready=1 → capture both lane vectors and training_data_type, clear accumulator, burst=0, lane=0 → ACC.
  - ACC: add one lane per cycle. After the last valid lane of the burst: if burst<B-1 → REQ, else → DONE.
  - REQ: data_request=1 for one cycle, burst++ → WAIT.
  - WAIT: ready=1 → capture lane vectors only (label is not re-captured), lane=0 → ACC.
  - DONE: load distance from the accumulator and data_type from the captured label, done=1 for one cycle → IDLE.
- ready is ignored in ACC, REQ and DONE.
- For T≤MAX_ELEMENTS the block runs one burst and never pulses data_request.

## Timing
- Reset state: distance=0, data_type=0, done=0, data_request=0, state IDLE, accumulator and counters 0.
- Reset mid-operation aborts the computation; no done is produced.
- All outputs are registered.
- Burst of L lanes accepted at edge e0: accumulations occur at edges e1..eL.
- Non-final burst: data_request is high in the cycle after eL.
- Final burst: done is high and distance is valid in the cycle after eL.
- Total latency from the final burst's ready to done is L+1 cycles.
- distance and data_type hold their value between done pulses.
- ready may be raised any cycle after data_request falls. The block waits indefinitely in WAIT.
- ready coinciding with the done cycle is ignored; the next vector starts on a ready sampled in IDLE.

## Structure
- Shared package holds:
  - state enum (IDLE, ACC, REQ, WAIT, DONE);
  - constant/function for burst count B = ceil(M*N/MAX_ELEMENTS);
  - constant/function for last-burst lane count.
- One natural sub-module: knn_abs_diff, a W-bit unsigned |a-b| unit.
- The top level holds FSM, lane/burst counters, capture registers, lane mux and accumulator.

## Test plan
- Defaults (T=60, bursts 16/16/16/12), training all 1, input all 0, random label 2 → three data_request pulses, then done with distance=60, data_type=2.
- Random elements 0..100, then 0..200, then 0..300, back-to-back vectors → each done's distance equals the software sum of |t-x|. The label is taken from the first burst even if training_data_type changes afterwards.
- M=2, N=4 (T=8<16), single burst: training {5,0,…}, input {0,5,…}, rest equal → no data_request; done 9 cycles after ready, distance=10.
- Wrap: T=2, training {2^W-1, 2^W-1}, input {0,0} → distance = 2^W-2.
- Extra ready pulses during ACC, and garbage in unused last-burst lanes → result unchanged.
- Assert rst during burst 2, then run a fresh vector → no done before the restart; outputs read 0 after reset; the fresh result is correct.
